// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_pkg
// Summary  : Shared fetch-path types, sizing constants and decoder opcodes.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

   localparam int INSTR_W     = 32;
   localparam int LINE_W      = 64;
   localparam int INSTR_BYTES = 4;
   localparam int LINE_BYTES  = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      DRAIN = 3'd3,
      FLUSH = 3'd4
   } fetch_state_t;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_REG    = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111,
      OP_SYSTEM = 7'b1110011
   } opcode_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : fetch_sequencer_if
// Summary   : Memory read port and decoder-side instruction handshake.
// Revision  : 1.0
// ============================================================================
interface fetch_sequencer_if #(
   parameter int ADDR_W = 64
);
   import fetch_pkg::*;

   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [ADDR_W-1:0]   mem_req_addr;
   logic                mem_resp_valid;
   logic [LINE_W-1:0]   mem_resp_data;
   logic                instr_valid;
   logic                instr_ready;
   logic [INSTR_W-1:0]  instr;
   logic [ADDR_W-1:0]   instr_pc;

   modport master (
      output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
      input  mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
      output mem_req_ready, mem_resp_valid, mem_resp_data, instr_ready
   );

endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Summary  : Fetches 64-bit lines and hands them to the decoder one word at a time.
// Revision : 1.0
// ============================================================================
module fetch_sequencer #(
   parameter int ADDR_W  = 64,
   parameter int LINE_W  = 64,
   parameter int INSTR_W = 32
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              start,
   input  wire logic [ADDR_W-1:0] entry_pc,
   input  wire logic              redirect_valid,
   input  wire logic [ADDR_W-1:0] redirect_pc,
   output logic                   busy,
   fetch_sequencer_if.master      bus
);
   import fetch_pkg::*;

   localparam logic [ADDR_W-1:0] C_WORD_MASK = ~ADDR_W'(INSTR_BYTES - 1);
   localparam logic [ADDR_W-1:0] C_LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

   fetch_state_t        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic                slot_q, slot_d;

   logic                mem_req_valid_q, mem_req_valid_d;
   logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
   logic                instr_valid_q, instr_valid_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
   logic                busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      line_d  = line_q;
      slot_d  = slot_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               pc_d    = entry_pc & C_WORD_MASK;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.mem_req_ready) state_d = WAIT;
         end
         WAIT: begin
            if (bus.mem_resp_valid) begin
               line_d  = bus.mem_resp_data;
               slot_d  = pc_q[2];
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.instr_ready) begin
               pc_d = pc_q + ADDR_W'(INSTR_BYTES);
               if (slot_q) state_d = REQ;
               else        slot_d  = 1'b1;
            end
         end
         FLUSH: begin
            if (bus.mem_resp_valid) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase

      // Redirect overrides everything; FLUSH is only needed while a response is still owed.
      if (redirect_valid && (state_q != IDLE)) begin
         pc_d   = redirect_pc & C_WORD_MASK;
         line_d = '0;
         slot_d = 1'b0;
         case (state_q)
            REQ:     state_d = bus.mem_req_ready  ? FLUSH : REQ;
            WAIT:    state_d = bus.mem_resp_valid ? REQ   : FLUSH;
            DRAIN:   state_d = REQ;
            FLUSH:   state_d = bus.mem_resp_valid ? REQ   : FLUSH;
            default: state_d = IDLE;
         endcase
      end

      // Outputs are registered from the next state so they line up with state_q.
      mem_req_valid_d = (state_d == REQ);
      mem_req_addr_d  = (state_d == REQ) ? (pc_d & C_LINE_MASK) : '0;
      instr_valid_d   = (state_d == DRAIN);
      instr_d         = '0;
      instr_pc_d      = '0;
      if (state_d == DRAIN) begin
         instr_d    = slot_d ? line_d[LINE_W-1 -: INSTR_W] : line_d[INSTR_W-1:0];
         instr_pc_d = pc_d;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         pc_q            <= '0;
         line_q          <= '0;
         slot_q          <= 1'b0;
         mem_req_valid_q <= 1'b0;
         mem_req_addr_q  <= '0;
         instr_valid_q   <= 1'b0;
         instr_q         <= '0;
         instr_pc_q      <= '0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         line_q          <= line_d;
         slot_q          <= slot_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_req_addr_q  <= mem_req_addr_d;
         instr_valid_q   <= instr_valid_d;
         instr_q         <= instr_d;
         instr_pc_q      <= instr_pc_d;
         busy_q          <= busy_d;
      end
   end

   assign bus.mem_req_valid = mem_req_valid_q;
   assign bus.mem_req_addr  = mem_req_addr_q;
   assign bus.instr_valid   = instr_valid_q;
   assign bus.instr         = instr_q;
   assign bus.instr_pc      = instr_pc_q;
   assign busy              = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Summary  : Directed scoreboard bench for fetch_sequencer.
// Revision : 1.0
// ============================================================================
module tb_fetch_sequencer;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } exp_instr_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [63:0] entry_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        busy;

   int          total = 0;
   int          bad   = 0;
   int          mem_lat = 1;
   logic        inject = 1'b0;

   logic [63:0] exp_a_q[$];
   exp_instr_t  exp_i_q[$];

   fetch_sequencer_if #(.ADDR_W(64)) bus ();

   fetch_sequencer #(.ADDR_W(64), .LINE_W(64), .INSTR_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .entry_pc       (entry_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
      .bus            (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Line contents: 0x1000 holds two known instructions, elsewhere each word is C0DE_<addr[15:0]>.
   function automatic logic [63:0] mem_line(input logic [63:0] a);
      logic [63:0] hi;
      hi = a + 64'd4;
      if (a == 64'h1000) return 64'h00500093_00000013;
      return {16'hC0DE, hi[15:0], 16'hC0DE, a[15:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: one outstanding read, response mem_lat cycles after acceptance.
   initial begin
      logic        acc;
      logic [63:0] acc_addr;
      logic        rst_seen;
      logic [63:0] pend;
      int          cnt;
      cnt = 0;
      pend = '0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      forever begin
         @(negedge clk);
         acc      = bus.mem_req_valid && bus.mem_req_ready;
         acc_addr = bus.mem_req_addr;
         rst_seen = reset;
         @(posedge clk);
         #2;
         bus.mem_resp_valid = 1'b0;
         if (rst_seen) cnt = 0;
         else if (acc) begin
            cnt  = mem_lat;
            pend = acc_addr;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.mem_resp_valid = 1'b1;
               bus.mem_resp_data  = mem_line(pend);
            end
         end
         if (inject) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 64'hBAAD_F00D_DEAD_BEEF;
         end
      end
   end

   // Monitor: pops the scoreboard on every handshake the DUT completes.
   initial begin
      exp_instr_t  e;
      logic [63:0] ea;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus.instr_valid && bus.instr_ready) begin
               if (exp_i_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_instr: got %h @%h expected none", bus.instr, bus.instr_pc);
               end else begin
                  e = exp_i_q.pop_front();
                  check("instr", {32'h0, bus.instr}, {32'h0, e.instr});
                  check("instr_pc", bus.instr_pc, e.pc);
               end
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
               if (exp_a_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_req: got %h expected none", bus.mem_req_addr);
               end else begin
                  ea = exp_a_q.pop_front();
                  check("mem_req_addr", bus.mem_req_addr, ea);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic pulse_start(input logic [63:0] pc);
      entry_pc = pc;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic push_i(input logic [31:0] i, input logic [63:0] pc);
      exp_instr_t e;
      e.instr = i;
      e.pc    = pc;
      exp_i_q.push_back(e);
   endtask

   task automatic drain_queues(input string name);
      int n = 0;
      while ((exp_a_q.size() != 0 || exp_i_q.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      total++;
      if (n >= 100) begin
         bad++;
         $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_a_q.size() + exp_i_q.size());
         exp_a_q.delete();
         exp_i_q.delete();
      end
   endtask

   task automatic wait_accept(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.mem_req_valid && bus.mem_req_ready) && n < 20);
      total++;
      if (n >= 20) begin
         bad++;
         $display("FAIL %s_accept_timeout: got none expected a request", name);
      end
   endtask

   task automatic wait_instr_valid(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.instr_valid && n < 20);
      total++;
      if (n >= 20) begin
         bad++;
         $display("FAIL %s_valid_timeout: got 0 expected 1", name);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_req_valid"}, {63'h0, bus.mem_req_valid}, 64'h0);
      check({name, "_instr_valid"}, {63'h0, bus.instr_valid}, 64'h0);
      check({name, "_busy"}, {63'h0, busy}, 64'h0);
      check({name, "_req_addr"}, bus.mem_req_addr, 64'h0);
      check({name, "_instr"}, {32'h0, bus.instr}, 64'h0);
      check({name, "_instr_pc"}, bus.instr_pc, 64'h0);
   endtask

   task automatic run_basic(input string name);
      exp_a_q.push_back(64'h1000);
      push_i(32'h00000013, 64'h1000);
      push_i(32'h00500093, 64'h1004);
      exp_a_q.push_back(64'h1008);
      pulse_start(64'h1000);
      drain_queues(name);
      do_reset();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset           = 1'b1;
      start           = 1'b0;
      entry_pc        = '0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      bus.mem_req_ready = 1'b1;
      bus.instr_ready   = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check_idle_outputs("reset");
      tick();
      reset = 1'b0;
      tick();

      // Aligned entry: both halves of the first line, then the next line.
      run_basic("aligned");

      // Unaligned entry: only the upper word of the first line.
      exp_a_q.push_back(64'h1000);
      push_i(32'h00500093, 64'h1004);
      exp_a_q.push_back(64'h1008);
      pulse_start(64'h1006);
      drain_queues("unaligned");
      do_reset();

      // Decoder stall: outputs frozen, no new request.
      bus.instr_ready = 1'b0;
      exp_a_q.push_back(64'h1000);
      pulse_start(64'h1000);
      wait_instr_valid("stall");
      for (int i = 0; i < 5; i++) begin
         check("stall_instr", {32'h0, bus.instr}, 64'h13);
         check("stall_pc", bus.instr_pc, 64'h1000);
         check("stall_req_valid", {63'h0, bus.mem_req_valid}, 64'h0);
         check("stall_instr_valid", {63'h0, bus.instr_valid}, 64'h1);
         @(negedge clk);
      end
      push_i(32'h00000013, 64'h1000);
      push_i(32'h00500093, 64'h1004);
      exp_a_q.push_back(64'h1008);
      tick();
      bus.instr_ready = 1'b1;
      drain_queues("stall");
      do_reset();

      // Redirect in WAIT; stale response arrives later and must be dropped.
      mem_lat = 4;
      exp_a_q.push_back(64'h1000);
      exp_a_q.push_back(64'h2000);
      push_i(32'hC0DE2000, 64'h2000);
      push_i(32'hC0DE2004, 64'h2004);
      exp_a_q.push_back(64'h2008);
      pulse_start(64'h1000);
      wait_accept("redirect");
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h2003;
      tick();
      redirect_valid = 1'b0;
      mem_lat        = 1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("flush_instr_valid", {63'h0, bus.instr_valid}, 64'h0);
         check("flush_req_valid", {63'h0, bus.mem_req_valid}, 64'h0);
         check("flush_busy", {63'h0, busy}, 64'h1);
      end
      drain_queues("redirect");
      do_reset();

      // PC wraps to zero after the top word of the address space.
      exp_a_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
      push_i(32'hC0DEFFFC, 64'hFFFF_FFFF_FFFF_FFFC);
      exp_a_q.push_back(64'h0);
      push_i(32'hC0DE0000, 64'h0);
      push_i(32'hC0DE0004, 64'h4);
      exp_a_q.push_back(64'h8);
      pulse_start(64'hFFFF_FFFF_FFFF_FFFC);
      drain_queues("wrap");
      do_reset();

      // Reset in DRAIN, then a stray response while IDLE.
      bus.instr_ready = 1'b0;
      exp_a_q.push_back(64'h1000);
      pulse_start(64'h1000);
      wait_instr_valid("midreset");
      tick();
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      inject = 1'b1;
      @(negedge clk);
      check_idle_outputs("midreset");
      tick();
      inject = 1'b0;
      @(negedge clk);
      check_idle_outputs("stray_resp");
      tick();
      bus.instr_ready = 1'b1;
      run_basic("restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
